// File: rtl/uart_alu_interface_if.sv
// Signal bundle between the UART RX/TX, the ALU and the command decoder.
// The slave modport is the decoder's view; master is the surrounding logic.
interface uart_alu_interface_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_err;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_err
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_err
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Command decoder: (header, value) byte pairs load operand A, operand B or the opcode;
// an opcode value triggers sampling of the ALU result and one UART TX transfer.
module uart_alu_interface #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_OP       = 6,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic                  clk,
  input logic                  i_rst,
  uart_alu_interface_if.slave  bus
);
  localparam int unsigned NB_TIMER = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [NB_TIMER-1:0] TimerLast = NB_TIMER'(TIMEOUT_CYC - 1);
  localparam logic [NB_TIMER-1:0] TimerMax  = {NB_TIMER{1'b1}};
  localparam logic [7:0] HdrA  = 8'h08;
  localparam logic [7:0] HdrB  = 8'h10;
  localparam logic [7:0] HdrOp = 8'h20;

  typedef enum logic [2:0] {StIdle, StWaitVal, StExec, StSend, StWaitTx} state_e;
  typedef enum logic [1:0] {SelA, SelB, SelOp} sel_e;

  state_e             state_q, state_d;
  sel_e               sel_q, sel_d;
  logic [NB_TIMER-1:0] timer_q, timer_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_q, tx_d;
  logic               err_q, err_d;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      sel_q   <= SelA;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_rx_done) begin
          state_d = StWaitVal;
          timer_d = '0;
          case (bus.i_rx_data[7:0])
            HdrA:    sel_d = SelA;
            HdrB:    sel_d = SelB;
            HdrOp:   sel_d = SelOp;
            default: begin
              state_d = StIdle;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StWaitVal: begin
        if (timer_q != TimerMax) timer_d = timer_q + NB_TIMER'(1);
        // An arriving byte takes priority over a simultaneous timeout.
        if (bus.i_rx_done) begin
          state_d = StIdle;
          case (sel_q)
            SelA:    a_d = bus.i_rx_data;
            SelB:    b_d = bus.i_rx_data;
            default: begin
              op_d    = bus.i_rx_data[NB_OP-1:0];
              state_d = StExec;
            end
          endcase
        end else if (timer_q == TimerLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StExec: begin
        tx_d    = bus.i_alu_result;
        state_d = StSend;
        err_d   = bus.i_rx_done;
      end
      StSend: begin
        state_d = StWaitTx;
        err_d   = bus.i_rx_done;
      end
      StWaitTx: begin
        if (bus.i_tx_done) state_d = StIdle;
        err_d = bus.i_rx_done;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.o_data_a   = a_q;
  assign bus.o_data_b   = b_q;
  assign bus.o_op       = op_q;
  assign bus.o_tx_data  = tx_q;
  assign bus.o_tx_start = (state_q == StSend);
  assign bus.o_err      = err_q;
endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface with a small behavioural ADD/SUB ALU.
module tb_uart_alu_interface;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  uart_alu_interface #(
    .NB_DATA    (8),
    .NB_OP      (6),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk  (clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always_comb begin
    bus.i_alu_result = 8'h00;
    case (bus.o_op)
      6'b100000: bus.i_alu_result = bus.o_data_a + bus.o_data_b;
      6'b100010: bus.i_alu_result = bus.o_data_a - bus.o_data_b;
      default:   bus.i_alu_result = 8'h00;
    endcase
  end

  int n_total = 0;
  int n_pass  = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endfunction

  // Scoreboard: every transmit start pops one expected result.
  always @(negedge clk) begin
    if (bus.o_err === 1'b1) err_cnt++;
    if (bus.o_tx_start === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_tx_start", 32'(bus.o_tx_data), 32'hFFFF_FFFF);
      else check("sb_tx_data", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  // Sends an OP pair and checks start latency; leaves the DUT in WAIT_TX.
  task automatic send_op(input logic [7:0] op, input logic [7:0] exp);
    send_byte(8'h20);
    exp_q.push_back(exp);
    send_byte(op);
    check("tx_start_n1", 32'(bus.o_tx_start), 32'd0);
    @(negedge clk);
    check("tx_start_n2", 32'(bus.o_tx_start), 32'd1);
    @(negedge clk);
    check("tx_start_once", 32'(bus.o_tx_start), 32'd0);
    check("tx_data_hold", 32'(bus.o_tx_data), 32'(exp));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[4];
  int   err_base;

  initial begin
    vecs[0] = '{a: 8'h01, b: 8'h01, op: 8'h20, exp: 8'h02};
    vecs[1] = '{a: 8'hFF, b: 8'h01, op: 8'h20, exp: 8'h00};
    vecs[2] = '{a: 8'h00, b: 8'h01, op: 8'h22, exp: 8'hFF};
    vecs[3] = '{a: 8'h05, b: 8'h03, op: 8'h22, exp: 8'h02};

    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_a", 32'(bus.o_data_a), 32'd0);
    check("rst_data_b", 32'(bus.o_data_b), 32'd0);
    check("rst_op", 32'(bus.o_op), 32'd0);
    check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    err_base = err_cnt;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h08);
      send_byte(vecs[i].a);
      send_byte(8'h10);
      send_byte(vecs[i].b);
      send_op(vecs[i].op, vecs[i].exp);
      check("vec_data_a", 32'(bus.o_data_a), 32'(vecs[i].a));
      check("vec_data_b", 32'(bus.o_data_b), 32'(vecs[i].b));
      check("vec_op", 32'(bus.o_op), 32'(vecs[i].op[5:0]));
      pulse_tx_done();
    end
    check("vec_no_err", 32'(err_cnt - err_base), 32'd0);

    // Operands persist; upper opcode bits are ignored.
    send_op(8'h20, 8'h08);
    pulse_tx_done();
    send_op(8'hE0, 8'h08);
    check("op_upper_ignored", 32'(bus.o_op), 32'h20);
    pulse_tx_done();

    // Bad header.
    err_base = err_cnt;
    send_byte(8'h55);
    @(negedge clk);
    check("bad_hdr_err", 32'(err_cnt - err_base), 32'd1);
    send_byte(8'h08);
    send_byte(8'h07);
    check("bad_hdr_then_a", 32'(bus.o_data_a), 32'h07);
    check("bad_hdr_single_err", 32'(err_cnt - err_base), 32'd1);

    // Timeout: no pulse early, exactly one pulse after expiry, A untouched.
    err_base = err_cnt;
    send_byte(8'h08);
    repeat (60) @(negedge clk);
    check("timeout_not_early", 32'(err_cnt - err_base), 32'd0);
    repeat (10) @(negedge clk);
    check("timeout_err", 32'(err_cnt - err_base), 32'd1);
    check("timeout_a_kept", 32'(bus.o_data_a), 32'h07);
    send_byte(8'h08);
    send_byte(8'h09);
    check("timeout_then_a", 32'(bus.o_data_a), 32'h09);

    // Byte arriving in the expiry cycle wins.
    err_base = err_cnt;
    send_byte(8'h08);
    repeat (63) @(negedge clk);
    send_byte(8'h0B);
    check("byte_wins_a", 32'(bus.o_data_a), 32'h0B);
    repeat (2) @(negedge clk);
    check("byte_wins_no_err", 32'(err_cnt - err_base), 32'd0);
    send_byte(8'h08);
    send_byte(8'h09);

    // Byte while busy in WAIT_TX is dropped with an error.
    err_base = err_cnt;
    send_op(8'h20, 8'h0C);
    send_byte(8'h08);
    @(negedge clk);
    check("busy_err", 32'(err_cnt - err_base), 32'd1);
    check("busy_a_kept", 32'(bus.o_data_a), 32'h09);
    check("busy_tx_hold", 32'(bus.o_tx_data), 32'h0C);
    pulse_tx_done();
    send_byte(8'h10);
    send_byte(8'h04);
    check("after_busy_b", 32'(bus.o_data_b), 32'h04);

    // Reset during WAIT_TX.
    send_op(8'h22, 8'h05);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_a", 32'(bus.o_data_a), 32'd0);
    check("mid_rst_b", 32'(bus.o_data_b), 32'd0);
    check("mid_rst_op", 32'(bus.o_op), 32'd0);
    check("mid_rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("mid_rst_tx_start", 32'(bus.o_tx_start), 32'd0);
    err_base = err_cnt;
    pulse_tx_done();
    repeat (2) @(negedge clk);
    check("late_tx_done_no_err", 32'(err_cnt - err_base), 32'd0);
    send_byte(8'h08);
    send_byte(8'h01);
    check("after_rst_a", 32'(bus.o_data_a), 32'h01);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
